// File: rtl/lock_pkg.sv
// Shared state codes and level helpers for the lock chain sequencer.
package lock_pkg;

    typedef logic [2:0] lock_state_t;

    localparam lock_state_t ST_IDLE      = 3'd0;
    localparam lock_state_t ST_EQUALIZE  = 3'd1;
    localparam lock_state_t ST_OPEN_WAIT = 3'd2;
    localparam lock_state_t ST_CLOSE     = 3'd3;
    localparam lock_state_t ST_DONE      = 3'd4;

    localparam int DEF_NUM_CHAMBERS = 2;
    localparam int DEF_LEVEL_W      = 8;
    localparam int DEF_OUTER_LEVEL  = 10;
    localparam int DEF_RISE         = 5;

    function automatic int rest_level(input int outer, input int rise, input int i);
        return outer + i * rise;
    endfunction

    // The inner pool sits one rise step above the last chamber.
    function automatic int inner_level(input int outer, input int rise, input int n);
        return rest_level(outer, rise, n + 1);
    endfunction

    function automatic logic is_chamber(input int region, input int n);
        return (region >= 1) && (region <= n);
    endfunction

    localparam int INNER_LEVEL = inner_level(DEF_OUTER_LEVEL, DEF_RISE, DEF_NUM_CHAMBERS);

endpackage

// File: rtl/lock_chamber.sv
// One lock chamber: a water level register stepped by one unit per enabled tick,
// saturating at both ends of the level range.
module lock_chamber #(
    parameter int                 LEVEL_W     = 8,
    parameter logic [LEVEL_W-1:0] RESET_LEVEL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               up,
    input  logic               tick,
    output logic [LEVEL_W-1:0] level
);

    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;

    always_comb begin
        level_d = level_q;
        if (en && tick) begin
            if (up) begin
                if (level_q != {LEVEL_W{1'b1}}) begin
                    level_d = level_q + LEVEL_W'(1);
                end
            end else begin
                if (level_q != '0) begin
                    level_d = level_q - LEVEL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= RESET_LEVEL;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/lock_chain_ctrl.sv
// Staircase lock sequencer: walks one gondola gate by gate between the outer
// and inner pools, equalising each gate's two sides before opening it.
//
// state        | meaning
// IDLE         | waiting for a pending or new request
// EQUALIZE     | stepping the adjusted chamber toward the other side of gate g
// OPEN_WAIT    | gate g open, levels frozen, waiting for gondola_clear
// CLOSE        | all gates shut, advance g or finish
// DONE         | one-cycle completion pulse, busy low
module lock_chain_ctrl
    import lock_pkg::*;
#(
    parameter  int NUM_CHAMBERS = DEF_NUM_CHAMBERS,
    parameter  int LEVEL_W      = DEF_LEVEL_W,
    parameter  int OUTER_LEVEL  = DEF_OUTER_LEVEL,
    parameter  int RISE         = DEF_RISE,
    localparam int PW           = $clog2(NUM_CHAMBERS + 2)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tick,
    input  logic                            arrive_req,
    input  logic                            depart_req,
    input  logic                            gondola_clear,
    output logic [NUM_CHAMBERS:0]           gate_open,
    output logic [NUM_CHAMBERS*LEVEL_W-1:0] chamber_level,
    output logic [PW-1:0]                   gondola_pos,
    output logic                            dir,
    output logic                            busy,
    output logic                            done
);

    localparam int POOL_INNER = inner_level(OUTER_LEVEL, RISE, NUM_CHAMBERS);

    lock_state_t           state_q, state_d;
    logic [PW-1:0]         gate_q, gate_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic                  dir_q, dir_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pend_up_q, pend_up_d;
    logic                  pend_down_q, pend_down_d;
    logic [NUM_CHAMBERS:0] gate_open_q, gate_open_d;

    logic [LEVEL_W-1:0]    region_lvl [0:NUM_CHAMBERS+1];
    logic [PW-1:0]         r_idx;
    logic [PW-1:0]         s_idx;
    logic [PW-1:0]         adj_idx;
    logic [LEVEL_W-1:0]    lvl_r;
    logic [LEVEL_W-1:0]    lvl_s;
    logic [LEVEL_W-1:0]    adj_cur;
    logic [LEVEL_W-1:0]    adj_target;
    logic                  levels_equal;
    logic                  adj_up;
    logic                  equalizing;
    logic [NUM_CHAMBERS-1:0] chamber_en;
    logic                  any_req;
    logic                  start_up;

    assign region_lvl[0]              = LEVEL_W'(OUTER_LEVEL);
    assign region_lvl[NUM_CHAMBERS+1] = LEVEL_W'(POOL_INNER);

    for (genvar i = 1; i <= NUM_CHAMBERS; i++) begin : g_chamber
        logic [LEVEL_W-1:0] lvl;

        lock_chamber #(
            .LEVEL_W     (LEVEL_W),
            .RESET_LEVEL (LEVEL_W'(rest_level(OUTER_LEVEL, RISE, i)))
        ) u_chamber (
            .clk   (clk),
            .reset (reset),
            .en    (chamber_en[i-1]),
            .up    (adj_up),
            .tick  (tick),
            .level (lvl)
        );

        assign chamber_en[i-1]                     = equalizing && (adj_idx == PW'(i));
        assign region_lvl[i]                       = lvl;
        assign chamber_level[i*LEVEL_W-1 -: LEVEL_W] = lvl;
    end

    // The gondola side is the reference unless it is a chamber; pools never move.
    always_comb begin
        r_idx = pos_q;
        s_idx = dir_q ? (gate_q + PW'(1)) : gate_q;
        lvl_r = region_lvl[r_idx];
        lvl_s = region_lvl[s_idx];
        levels_equal = (lvl_r == lvl_s);
        if (is_chamber(int'(r_idx), NUM_CHAMBERS)) begin
            adj_idx    = r_idx;
            adj_cur    = lvl_r;
            adj_target = lvl_s;
        end else begin
            adj_idx    = s_idx;
            adj_cur    = lvl_s;
            adj_target = lvl_r;
        end
        adj_up     = (adj_target > adj_cur);
        equalizing = (state_q == ST_EQUALIZE) && !levels_equal;
    end

    always_comb begin
        state_d     = state_q;
        gate_d      = gate_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        gate_open_d = '0;
        pend_up_d   = pend_up_q;
        pend_down_d = pend_down_q;
        any_req     = pend_up_q | pend_down_q | arrive_req | depart_req;
        start_up    = pend_up_q | (!pend_down_q & arrive_req);

        if (state_q != ST_IDLE) begin
            pend_up_d   = pend_up_q | arrive_req;
            pend_down_d = pend_down_q | depart_req;
        end

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (any_req) begin
                    state_d = ST_EQUALIZE;
                    busy_d  = 1'b1;
                    if (start_up) begin
                        dir_d       = 1'b1;
                        gate_d      = '0;
                        pos_d       = '0;
                        pend_up_d   = 1'b0;
                        pend_down_d = pend_down_q | depart_req;
                    end else begin
                        dir_d       = 1'b0;
                        gate_d      = PW'(NUM_CHAMBERS);
                        pos_d       = PW'(NUM_CHAMBERS + 1);
                        pend_down_d = 1'b0;
                        pend_up_d   = pend_up_q | arrive_req;
                    end
                end
            end
            ST_EQUALIZE: begin
                if (levels_equal) begin
                    state_d             = ST_OPEN_WAIT;
                    gate_open_d[gate_q] = 1'b1;
                end
            end
            ST_OPEN_WAIT: begin
                if (gondola_clear) begin
                    state_d = ST_CLOSE;
                    pos_d   = s_idx;
                end else begin
                    gate_open_d[gate_q] = 1'b1;
                end
            end
            ST_CLOSE: begin
                if (dir_q ? (gate_q == PW'(NUM_CHAMBERS)) : (gate_q == '0)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_EQUALIZE;
                    gate_d  = dir_q ? (gate_q + PW'(1)) : (gate_q - PW'(1));
                end
            end
            ST_DONE: begin
                // busy rises already in the IDLE cycle when work is queued.
                state_d = ST_IDLE;
                busy_d  = any_req;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gate_q      <= '0;
            pos_q       <= '0;
            dir_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pend_up_q   <= 1'b0;
            pend_down_q <= 1'b0;
            gate_open_q <= '0;
        end else begin
            state_q     <= state_d;
            gate_q      <= gate_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pend_up_q   <= pend_up_d;
            pend_down_q <= pend_down_d;
            gate_open_q <= gate_open_d;
        end
    end

    assign gate_open   = gate_open_q;
    assign gondola_pos = pos_q;
    assign dir         = dir_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
